// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch definitions: sequencer state encodings and PC source codes,
// used by fetch_sequencer and the IF stage datapath.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'd0,
        FS_FETCH    = 3'd1,
        FS_WAIT_MEM = 3'd2,
        FS_STALL    = 3'd3,
        FS_FLUSH    = 3'd4
    } fetch_state_t;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
    localparam logic [1:0] PC_SEL_EXCEPT = 2'b11;

    // Redirect target by priority: exception > jump > taken branch.
    function automatic logic [1:0] redirect_sel(input logic exc, input logic jmp);
        if (exc)
            return PC_SEL_EXCEPT;
        else if (jmp)
            return PC_SEL_JUMP;
        else
            return PC_SEL_BRANCH;
    endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter, cleared by the asynchronous active-low reset.
module fetch_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: steers PC and IF/ID register enables.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   imem_ready,
    input  logic                   hazard_stall,
    input  logic                   p2_isBranch,
    input  logic                   p2_alu_flag_N,
    input  logic                   isJump,
    input  logic                   isException,
    output logic                   imem_req,
    output logic                   pcWrite,
    output logic [1:0]             pc_sel,
    output logic                   p1_pipeline_regWrite,
    output logic                   p1_flush,
`ifdef FETCH_PERF_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [STALL_CNT_W-1:0] redirect_count,
`endif
    output logic [2:0]             fsm_state
);

    fetch_state_t state_reg;
    fetch_state_t state_next;
    logic         redirect;

    assign redirect  = isException | isJump | (p2_isBranch & p2_alu_flag_N);
    assign fsm_state = state_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= FS_IDLE;
        else
            state_reg <= state_next;
    end

    // Reset holds state_reg at IDLE, which already forces every output low.
    always_comb begin
        imem_req             = 1'b0;
        pcWrite              = 1'b0;
        pc_sel               = PC_SEL_PLUS4;
        p1_pipeline_regWrite = 1'b0;
        p1_flush             = 1'b0;
        state_next           = state_reg;
        case (state_reg)
            FS_IDLE: begin
                state_next = FS_FETCH;
            end
            FS_FETCH, FS_WAIT_MEM, FS_STALL: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pcWrite    = 1'b1;
                    pc_sel     = redirect_sel(isException, isJump);
                    p1_flush   = 1'b1;
                    state_next = FS_FLUSH;
                end else if (hazard_stall) begin
                    state_next = FS_STALL;
                end else if (!imem_ready) begin
                    state_next = FS_WAIT_MEM;
                end else begin
                    pcWrite              = 1'b1;
                    p1_pipeline_regWrite = 1'b1;
                    state_next           = FS_FETCH;
                end
            end
            FS_FLUSH: begin
                imem_req = 1'b1;
                // Only an exception may preempt the bubble; jump/branch are stale.
                if (isException) begin
                    pcWrite    = 1'b1;
                    pc_sel     = PC_SEL_EXCEPT;
                    p1_flush   = 1'b1;
                    state_next = FS_FLUSH;
                end else begin
                    state_next = FS_FETCH;
                end
            end
            default: begin
                state_next = FS_IDLE;
            end
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic [1:0]             cnt_inc;
    logic [STALL_CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = (state_reg == FS_STALL) || (state_reg == FS_WAIT_MEM);
    assign cnt_inc[1] = p1_flush;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            fetch_perf_counter #(
                .W(STALL_CNT_W)
            ) u_cnt (
                .clk  (clk),
                .reset(reset),
                .inc  (cnt_inc[gi]),
                .count(cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cycles   = cnt_val[0];
    assign redirect_count = cnt_val[1];
`endif

endmodule
